// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm dismissal-code controller.
package alarm_pkg;

  localparam int unsigned LFSR_W  = 8;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned CNT_W   = 4;

  localparam logic [LFSR_W-1:0]  LFSR_SEED = 8'h01;
  // x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register: bits 7,5,4,3
  localparam logic [LFSR_W-1:0]  LFSR_TAPS = 8'hB8;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    ENTRY,
    CHECK
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/digit_lfsr.sv
// Free-running Fibonacci LFSR feeding the code generator.
// Optional seed reload ports under ALARM_CHALLENGE_SEED_LOAD_EN.
module digit_lfsr
  import alarm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
`ifdef ALARM_CHALLENGE_SEED_LOAD_EN
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
`endif
  output logic [LFSR_W-1:0] value
);

  // A zero seed would lock the register, so it falls back to the reset seed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= LFSR_SEED;
    end
`ifdef ALARM_CHALLENGE_SEED_LOAD_EN
    else if (load) begin
      value <= (seed == '0) ? LFSR_SEED : seed;
    end
`endif
    else begin
      value <= lfsr_step(value);
    end
  end

endmodule

// File: rtl/alarm_challenge_ctrl.sv
// Builds a random keypad dismissal code when the alarm fires and checks entered codes.
// Optional LFSR seed reload (seed_load/seed_in) under ALARM_CHALLENGE_SEED_LOAD_EN.
module alarm_challenge_ctrl
  import alarm_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MAX_TRIES  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alarm_trig,
  input  logic                          key_valid,
  input  logic [DIGIT_W-1:0]            key_digit,
`ifdef ALARM_CHALLENGE_SEED_LOAD_EN
  input  logic                          seed_load,
  input  logic [LFSR_W-1:0]             seed_in,
`endif
  output logic                          key_ready,
  output logic [DIGIT_W*NUM_DIGITS-1:0] code_digits,
  output logic                          code_valid,
  output logic                          alarm_on,
  output logic                          dismissed,
  output logic [CNT_W-1:0]              fail_cnt
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] LAST_TRY = CNT_W'(MAX_TRIES - 1);

  state_t                                 state, state_nxt;
  logic [IDX_W-1:0]                       idx, idx_nxt;
  logic                                   mismatch, mismatch_nxt;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]     code_q, code_nxt;
  logic                                   code_valid_nxt, alarm_on_nxt, dismissed_nxt, key_ready_nxt;
  logic [CNT_W-1:0]                       fail_cnt_nxt;

  logic [LFSR_W-1:0]  lfsr;
  logic [DIGIT_W-1:0] cand;
  logic               cand_ok;
  logic               xfer;
  logic               key_bad;

  digit_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
`ifdef ALARM_CHALLENGE_SEED_LOAD_EN
    .load  (seed_load),
    .seed  (seed_in),
`endif
    .value (lfsr)
  );

  // Rejection sampling: only BCD candidates are kept; the nonzero guard covers a stuck register
  assign cand    = lfsr[DIGIT_W-1:0];
  assign cand_ok = (lfsr != '0) && (cand <= DIGIT_MAX);
  assign xfer    = key_valid && key_ready;
  assign key_bad = (key_digit > DIGIT_MAX) || (key_digit != code_q[idx]);

  assign code_digits = code_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      mismatch   <= 1'b0;
      code_q     <= '0;
      code_valid <= 1'b0;
      alarm_on   <= 1'b0;
      dismissed  <= 1'b0;
      fail_cnt   <= '0;
      key_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      mismatch   <= mismatch_nxt;
      code_q     <= code_nxt;
      code_valid <= code_valid_nxt;
      alarm_on   <= alarm_on_nxt;
      dismissed  <= dismissed_nxt;
      fail_cnt   <= fail_cnt_nxt;
      key_ready  <= key_ready_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    mismatch_nxt   = mismatch;
    code_nxt       = code_q;
    code_valid_nxt = code_valid;
    alarm_on_nxt   = alarm_on;
    dismissed_nxt  = 1'b0;
    fail_cnt_nxt   = fail_cnt;

    unique case (state)
      IDLE: begin
        if (alarm_trig) begin
          state_nxt    = GEN;
          idx_nxt      = '0;
          alarm_on_nxt = 1'b1;
        end
      end

      GEN: begin
        if (cand_ok) begin
          code_nxt[idx] = cand;
          if (idx == LAST_IDX) begin
            state_nxt      = ENTRY;
            idx_nxt        = '0;
            mismatch_nxt   = 1'b0;
            code_valid_nxt = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end

      ENTRY: begin
        if (xfer) begin
          if (key_bad) mismatch_nxt = 1'b1;
          if (idx == LAST_IDX) begin
            state_nxt = CHECK;
            idx_nxt   = '0;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end

      CHECK: begin
        if (!mismatch) begin
          state_nxt      = IDLE;
          dismissed_nxt  = 1'b1;
          alarm_on_nxt   = 1'b0;
          code_valid_nxt = 1'b0;
          fail_cnt_nxt   = '0;
        end else if (fail_cnt == LAST_TRY) begin
          // Too many misses: throw the code away and draw a fresh one
          state_nxt      = GEN;
          fail_cnt_nxt   = '0;
          code_valid_nxt = 1'b0;
          idx_nxt        = '0;
        end else begin
          state_nxt    = ENTRY;
          fail_cnt_nxt = fail_cnt + CNT_W'(1);
          idx_nxt      = '0;
          mismatch_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    key_ready_nxt = (state_nxt == ENTRY);
  end

endmodule
